// File: rtl/reciprocal_float_cu.sv
// reciprocal_float_cu: control unit for the floating-point reciprocal datapath.
// Sequences operand load, exponent commit, CORDIC start, bounded completion
// wait and the done pulse. Optional macro RECIP_ZERO_TRAP_EN enables the
// zero-operand trap (skip the CORDIC and flag div_zero).
//
// Handshake: start is a level request sampled only in IDLE; done_cordic is a
// one-cycle completion pulse honoured only in WAIT; done is a one-cycle pulse
// and div_zero/timeout_err are valid with it and hold until the next LOAD.
module reciprocal_float_cu #(
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done_cordic,
  input  logic       zero_flag,
  output logic       loadE,
  output logic       loadM,
  output logic       loadS,
  output logic       selE,
  output logic       start_cordic,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       timeout_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Last counter value at which WAIT may still accept done_cordic.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       zero_trap;
  logic       wait_expired;

`ifdef RECIP_ZERO_TRAP_EN
  assign zero_trap = zero_flag;
`else
  // Zero operands take the normal CORDIC path; the flag is not consulted.
  logic zero_flag_unused;
  assign zero_flag_unused = zero_flag;
  assign zero_trap        = 1'b0;
`endif

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign state_dbg    = state;

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and control decode (decoded from state).
  always_comb begin
    state_nxt    = state;
    loadE        = 1'b0;
    loadM        = 1'b0;
    loadS        = 1'b0;
    selE         = 1'b0;
    start_cordic = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        loadE     = 1'b1;
        loadM     = 1'b1;
        loadS     = 1'b1;
        selE      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: begin
        // Commit 253-E+cin unless the operand is trapped as zero.
        loadE     = !zero_trap;
        state_nxt = zero_trap ? S_FIN : S_START;
      end
      S_START: begin
        start_cordic = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (done_cordic || wait_expired) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait counter: cleared in START, saturating increment in WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wait_cnt <= 8'd0;
    else if (state == S_START)                 wait_cnt <= 8'd0;
    else if (state == S_WAIT && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
  end

  // Status flags: cleared when a run is accepted, set on the way to FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        div_zero    <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (state == S_CHECK && zero_trap)                      div_zero    <= 1'b1;
      if (state == S_WAIT && !done_cordic && wait_expired)    timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reciprocal_float_cu.sv
// tb_reciprocal_float_cu: randomized scoreboard bench for reciprocal_float_cu.
// A driver issues runs and pushes expected event cycles computed from the
// latency rules; a negedge monitor pops and compares as events appear.
module tb_reciprocal_float_cu;

  localparam int T = 5;

  logic       clk;
  logic       rst;
  logic       start;
  logic       done_cordic;
  logic       zero_flag;
  logic       loadE, loadM, loadS, selE, start_cordic;
  logic       busy, done, div_zero, timeout_err;
  logic [2:0] state_dbg;

  typedef struct {
    int cyc;
    bit dz;
    bit to;
  } done_exp_t;

  int        load_q[$];
  int        check_q[$];
  int        sc_q[$];
  done_exp_t done_q[$];

  int n_vec;
  int n_err;
  int cyc;
  bit last_dz;
  bit last_to;

  reciprocal_float_cu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .done_cordic(done_cordic),
    .zero_flag(zero_flag), .loadE(loadE), .loadM(loadM), .loadS(loadS),
    .selE(selE), .start_cordic(start_cordic), .busy(busy), .done(done),
    .div_zero(div_zero), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every observed event against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (loadM) begin
        if (load_q.size() == 0) check("load_unexpected", cyc, -1);
        else check("load_cycle", cyc, load_q.pop_front());
        check("load_ctrl", {loadE, loadS, selE, start_cordic}, 4'b1110);
        check("load_flags_clear", {div_zero, timeout_err}, 0);
      end
      if (loadE && !selE) begin
        if (check_q.size() == 0) check("commit_unexpected", cyc, -1);
        else check("commit_cycle", cyc, check_q.pop_front());
      end
      if (start_cordic) begin
        if (sc_q.size() == 0) check("start_cordic_unexpected", cyc, -1);
        else check("start_cordic_cycle", cyc, sc_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) check("done_unexpected", cyc, -1);
        else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("div_zero", int'(div_zero), int'(e.dz));
          check("timeout_err", int'(timeout_err), int'(e.to));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  // One run: k = WAIT index of the done_cordic pulse (negative = none).
  task automatic run_op(input int k, input bit hold, input bit zf);
    int  s;
    int  n;
    bit  to;
    bit  trap;
    wait_idle();
    check("flags_held", {div_zero, timeout_err}, {last_dz, last_to});
    start     = 1'b1;
    zero_flag = zf;
    s         = cyc;
`ifdef RECIP_ZERO_TRAP_EN
    trap = zf;
`else
    trap = 1'b0;
`endif
    load_q.push_back(s + 1);
    if (trap) begin
      done_q.push_back('{s + 3, 1'b1, 1'b0});
      last_dz = 1'b1;
      last_to = 1'b0;
    end else begin
      to = !(k >= 0 && k <= T - 1);
      n  = to ? T - 1 : k;
      check_q.push_back(s + 2);
      sc_q.push_back(s + 3);
      done_q.push_back('{s + 5 + n, 1'b0, to});
      last_dz = 1'b0;
      last_to = to;
    end
    tick();
    if (!hold) start = 1'b0;
    if (k >= 0) begin
      while (cyc < s + 4 + k) tick();
      done_cordic = 1'b1;
      tick();
      done_cordic = 1'b0;
    end
  endtask

  // Stimulus.
  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    start = 0; done_cordic = 0; zero_flag = 0;
    last_dz = 0; last_to = 0;
    rst = 1'b0;
    repeat (3) tick();
    check("reset_outputs",
          {loadE, loadM, loadS, selE, start_cordic, busy, done, div_zero, timeout_err}, 0);
    rst = 1'b1;
    tick();

    // Directed: nominal, timeout, recovery, coincidence, spurious/held start.
    run_op(4, 1'b0, 1'b0);
    run_op(-1, 1'b0, 1'b0);
    run_op(0, 1'b0, 1'b0);
    run_op(T - 1, 1'b0, 1'b0);
    run_op(T, 1'b0, 1'b0);
    repeat (2) tick();
    done_cordic = 1'b1; tick(); done_cordic = 1'b0;
    repeat (2) tick();
    run_op(2, 1'b1, 1'b0);
    run_op(1, 1'b0, 1'b1);

    // Reset in the middle of WAIT.
    begin
      int s;
      wait_idle();
      start = 1'b1; s = cyc;
      load_q.push_back(s + 1); check_q.push_back(s + 2); sc_q.push_back(s + 3);
      tick(); start = 1'b0;
      while (cyc < s + 6) tick();
      #2 rst = 1'b0;
      #1 check("reset_mid_wait",
               {loadE, loadM, loadS, selE, start_cordic, busy, done, div_zero, timeout_err}, 0);
      done_q.delete();
      last_dz = 0; last_to = 0;
      tick();
      rst = 1'b1;
      tick();
    end
    run_op(3, 1'b0, 1'b0);

    // Randomized runs.
    for (int i = 0; i < 60; i++) begin
      int  k;
      bit  hold;
      bit  zf;
      k    = int'($urandom_range(0, T + 3)) - 1;
      hold = ($urandom_range(0, 3) == 0) && (k >= 0) && (k <= T - 1);
      zf   = hold ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(k, hold, zf);
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        if (!start) begin
          done_cordic = 1'b1; tick(); done_cordic = 1'b0;
        end
      end
    end
    start = 1'b0;
    wait_idle();
    repeat (20) tick();

    check("load_q_drained", load_q.size(), 0);
    check("commit_q_drained", check_q.size(), 0);
    check("start_cordic_q_drained", sc_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
